// File: rtl/mhpm_counter_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mhpm_counter_bank
// Purpose  : Machine-mode performance counter bank. Provides mcycle,
//            minstret, NUM_HPM programmable mhpmcounter/mhpmevent pairs
//            (indices 3..2+NUM_HPM) and mcountinhibit. It claims its CSR
//            addresses through csr_hit.
// Ports    : CLK, RST (sync, active-high)
//            csr_addr/csr_wen/csr_wdata : CSR write, always a full 32 bits
//            csr_rdata/csr_hit          : combinational read data and decode
//            inst_retired, event_vec    : per-cycle pulses, registered once
//            ovf_irq                    : registered OR of the OF flags
// Options  : MHPM_OVF_IRQ_EN enables mhpmevent OF (bit 31) and OINH (bit 30)
//            and drives ovf_irq. When it is undefined, those bits read 0 and
//            ovf_irq is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module mhpm_counter_bank #(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int HPM_WIDTH  = 40
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [11:0]           csr_addr,
    input  logic                  csr_wen,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_hit,
    input  logic                  inst_retired,
    input  logic [NUM_EVENTS-1:0] event_vec,
    output logic                  ovf_irq
);

    localparam int c_SEL_W = $clog2(NUM_EVENTS + 1);
    localparam int c_HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int c_HI_W  = HPM_WIDTH - 32;
    // Implemented inhibit bits: CY, IR and one bit per implemented counter.
    localparam logic [31:0] c_INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic [63:0]           r_mcycle;
    logic [63:0]           r_minstret;
    logic [HPM_WIDTH-1:0]  r_hpm [c_HPM_N];
    logic [c_SEL_W-1:0]    r_sel [c_HPM_N];
    logic [31:0]           r_inhibit;
    logic [NUM_EVENTS-1:0] r_ev_q;
    logic                  r_ir_q;

    logic [4:0]            w_idx;
    logic                  w_cnt_lo;
    logic                  w_cnt_hi;
    logic                  w_evt;
    logic                  w_inh;
    logic [c_HPM_N-1:0]    w_hpm_inc;
    logic [31:0]           w_rdata;

    // Address decode: B00..B1F low halves, B80..B9F high halves, 320..33F events.
    assign w_idx    = csr_addr[4:0];
    assign w_cnt_lo = (csr_addr[11:5] == 7'h58);
    assign w_cnt_hi = (csr_addr[11:5] == 7'h5C);
    assign w_evt    = (csr_addr[11:5] == 7'h19) && (w_idx >= 5'd3);
    assign w_inh    = (csr_addr == 12'h320);
    assign csr_hit  = ((w_cnt_lo || w_cnt_hi) && (w_idx != 5'd1)) || w_evt || w_inh;

    // Increment request per counter from the registered event stage. The
    // selector and inhibit used are the ones current in the increment cycle.
    always_comb begin
        w_hpm_inc = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (!r_inhibit[i + 3] && (r_sel[i] == c_SEL_W'(e + 1)) && r_ev_q[e]) begin
                    w_hpm_inc[i] = 1'b1;
                end
            end
        end
    end

`ifdef MHPM_OVF_IRQ_EN
    logic [c_HPM_N-1:0] r_of;
    logic [c_HPM_N-1:0] r_oinh;
    logic               r_ovf_irq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_of      <= '0;
            r_oinh    <= '0;
            r_ovf_irq <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_wen && w_evt && (w_idx == 5'(i + 3))) begin
                    r_of[i]   <= csr_wdata[31];
                    r_oinh[i] <= csr_wdata[30];
                end
                // Only a wrap caused by an increment sets OF; a write that
                // collides with the increment drops the increment entirely.
                if (w_hpm_inc[i] && (&r_hpm[i]) && !r_oinh[i] &&
                    !(csr_wen && (w_cnt_lo || w_cnt_hi) && (w_idx == 5'(i + 3)))) begin
                    r_of[i] <= 1'b1;
                end
            end
            r_ovf_irq <= |r_of;
        end
    end

    assign ovf_irq = r_ovf_irq;
`else
    assign ovf_irq = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_inhibit  <= '0;
            r_ev_q     <= '0;
            r_ir_q     <= 1'b0;
            for (int i = 0; i < c_HPM_N; i++) begin
                r_hpm[i] <= '0;
                r_sel[i] <= '0;
            end
        end else begin
            r_ev_q <= event_vec;
            r_ir_q <= inst_retired;

            // A write to either half wins and suppresses that cycle's increment.
            if (csr_wen && w_cnt_lo && (w_idx == 5'd0)) begin
                r_mcycle[31:0] <= csr_wdata;
            end else if (csr_wen && w_cnt_hi && (w_idx == 5'd0)) begin
                r_mcycle[63:32] <= csr_wdata;
            end else if (!r_inhibit[0]) begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (csr_wen && w_cnt_lo && (w_idx == 5'd2)) begin
                r_minstret[31:0] <= csr_wdata;
            end else if (csr_wen && w_cnt_hi && (w_idx == 5'd2)) begin
                r_minstret[63:32] <= csr_wdata;
            end else if (!r_inhibit[2] && r_ir_q) begin
                r_minstret <= r_minstret + 64'd1;
            end

            if (csr_wen && w_inh) begin
                r_inhibit <= csr_wdata & c_INH_MASK;
            end

            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_wen && w_cnt_lo && (w_idx == 5'(i + 3))) begin
                    r_hpm[i][31:0] <= csr_wdata;
                end else if (csr_wen && w_cnt_hi && (w_idx == 5'(i + 3))) begin
                    r_hpm[i][HPM_WIDTH-1:32] <= csr_wdata[c_HI_W-1:0];
                end else if (w_hpm_inc[i]) begin
                    r_hpm[i] <= r_hpm[i] + HPM_WIDTH'(1);
                end
                if (csr_wen && w_evt && (w_idx == 5'(i + 3))) begin
                    r_sel[i] <= csr_wdata[c_SEL_W-1:0];
                end
            end
        end
    end

    // Read mux; unimplemented indices and misses return 0.
    always_comb begin
        w_rdata = '0;
        if (w_cnt_lo || w_cnt_hi) begin
            if (w_idx == 5'd0) begin
                w_rdata = w_cnt_hi ? r_mcycle[63:32] : r_mcycle[31:0];
            end else if (w_idx == 5'd2) begin
                w_rdata = w_cnt_hi ? r_minstret[63:32] : r_minstret[31:0];
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (w_idx == 5'(i + 3)) begin
                        w_rdata = w_cnt_hi ? 32'(r_hpm[i][HPM_WIDTH-1:32]) : r_hpm[i][31:0];
                    end
                end
            end
        end else if (w_inh) begin
            w_rdata = r_inhibit;
        end else if (w_evt) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (w_idx == 5'(i + 3)) begin
                    w_rdata = 32'(r_sel[i]);
`ifdef MHPM_OVF_IRQ_EN
                    w_rdata[31] = r_of[i];
                    w_rdata[30] = r_oinh[i];
`endif
                end
            end
        end
    end

    assign csr_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mhpm_counter_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mhpm_counter_bank
// Purpose  : Self-checking bench for mhpm_counter_bank (NUM_HPM=4,
//            NUM_EVENTS=8, HPM_WIDTH=40). Decode vectors come from a table;
//            the event pipeline is checked against a small cycle model, and
//            the carry, inhibit, reset and wrap corners use hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mhpm_counter_bank;

    localparam int NUM_HPM    = 4;
    localparam int NUM_EVENTS = 8;
    localparam int HPM_WIDTH  = 40;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [11:0]           csr_addr = '0;
    logic                  csr_wen = 1'b0;
    logic [31:0]           csr_wdata = '0;
    logic [31:0]           csr_rdata;
    logic                  csr_hit;
    logic                  inst_retired = 1'b0;
    logic [NUM_EVENTS-1:0] event_vec = '0;
    logic                  ovf_irq;

    mhpm_counter_bank #(
        .NUM_HPM    (NUM_HPM),
        .NUM_EVENTS (NUM_EVENTS),
        .HPM_WIDTH  (HPM_WIDTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .csr_addr     (csr_addr),
        .csr_wen      (csr_wen),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_hit      (csr_hit),
        .inst_retired (inst_retired),
        .event_vec    (event_vec),
        .ovf_irq      (ovf_irq)
    );

    always #50 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [11:0] addr;
        logic        hit;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [14];

    // Expected value is queued with the stimulus and popped once the
    // combinational read has settled.
    task automatic check_rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        exp_q.push_back(exp);
        csr_addr = a;
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (csr_rdata !== e) begin
            n_err++;
            $display("FAIL %s: addr %h rdata %h expected %h", name, a, csr_rdata, e);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        @(posedge CLK);
        #1;
        csr_wen = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          ir_cnt;
        logic        pipe_ev;
        logic        pipe_ir;
        logic        ev;
        logic        ir;

        vt[0]  = '{12'h7C0, 1'b0, 32'h0};
        vt[1]  = '{12'hB00, 1'b1, 32'h0};
        vt[2]  = '{12'hB01, 1'b0, 32'h0};
        vt[3]  = '{12'hB02, 1'b1, 32'h0};
        vt[4]  = '{12'hB1F, 1'b1, 32'h0};
        vt[5]  = '{12'hB9F, 1'b1, 32'h0};
        vt[6]  = '{12'hB81, 1'b0, 32'h0};
        vt[7]  = '{12'h320, 1'b1, 32'h0};
        vt[8]  = '{12'h321, 1'b0, 32'h0};
        vt[9]  = '{12'h322, 1'b0, 32'h0};
        vt[10] = '{12'h323, 1'b1, 32'h0};
        vt[11] = '{12'h33F, 1'b1, 32'h0};
        vt[12] = '{12'h340, 1'b0, 32'h0};
        vt[13] = '{12'hB20, 1'b0, 32'h0};

        // Reset state and decode table, with reset held.
        step(2);
        for (int i = 0; i < 14; i++) begin
            check_rd(vt[i].addr, vt[i].rdata, "decode_rdata");
            check1("decode_hit", csr_hit, vt[i].hit);
        end
        check1("reset_ovf_irq", ovf_irq, 1'b0);

        // Ten idle cycles after reset release.
        RST = 1'b0;
        step(10);
        check_rd(12'hB00, 32'd10, "mcycle_idle");
        check_rd(12'hB80, 32'd0,  "mcycleh_idle");
        check_rd(12'hB02, 32'd0,  "minstret_idle");
        for (int i = 3; i < 7; i++) check_rd(12'h320 + 12'(i), 32'd0, "mhpmevent_reset");

        // Event pipeline versus a one-register model.
        wr(12'h323, 32'd2);
        check_rd(12'h323, 32'd2, "mhpmevent3_rd");
        cnt = 0; ir_cnt = 0; pipe_ev = 1'b0; pipe_ir = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ev = (c < 5);
            ir = (c < 3);
            event_vec    = ev ? 8'h02 : 8'h00;
            inst_retired = ir;
            check_rd(12'hB03, 32'(cnt),    "hpm3_pipe");
            check_rd(12'hB02, 32'(ir_cnt), "minstret_pipe");
            step(1);
            cnt     = cnt + int'(pipe_ev);
            pipe_ev = ev;
            ir_cnt  = ir_cnt + int'(pipe_ir);
            pipe_ir = ir;
        end
        event_vec    = '0;
        inst_retired = 1'b0;
        check_rd(12'hB03, 32'd5, "hpm3_total");
        check_rd(12'hB83, 32'd0, "hpm3h_total");
        check_rd(12'hB02, 32'd3, "minstret_total");

        // Unimplemented indices and WARL selector.
        wr(12'hB08, 32'h1234);
        check_rd(12'hB08, 32'h0, "hpm8_unimpl");
        check1("hpm8_hit", csr_hit, 1'b1);
        wr(12'h328, 32'h3);
        check_rd(12'h328, 32'h0, "event8_unimpl");
        wr(12'h323, 32'hFF);
        check_rd(12'h323, 32'h0F, "event3_warl");
        event_vec = 8'hFF;
        step(3);
        event_vec = 8'h00;
        step(2);
        check_rd(12'hB03, 32'd5, "hpm3_sel_oob");

        // mcycle low-to-high carry and write priority.
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        check_rd(12'hB00, 32'hFFFF_FFFF, "mcycle_preload");
        step(1);
        check_rd(12'hB80, 32'd1, "mcycleh_carry");
        check_rd(12'hB00, 32'd0, "mcycle_carry");
        wr(12'hB00, 32'hABCD_0000);
        check_rd(12'hB00, 32'hABCD_0000, "mcycle_write_wins");
        check_rd(12'hB80, 32'd1,         "mcycleh_hold");
        step(1);
        check_rd(12'hB00, 32'hABCD_0001, "mcycle_resume");

        // mcountinhibit: CY and IR frozen, hpm4 still counts.
        wr(12'h324, 32'd1);
        wr(12'h320, 32'h5);
        check_rd(12'h320, 32'h5, "inhibit_rd");
        inst_retired = 1'b1;
        event_vec    = 8'h01;
        step(20);
        inst_retired = 1'b0;
        event_vec    = 8'h00;
        step(2);
        check_rd(12'hB00, 32'hABCD_0003, "mcycle_frozen");
        check_rd(12'hB02, 32'd3,         "minstret_frozen");
        check_rd(12'hB04, 32'd20,        "hpm4_uninhibited");
        wr(12'h320, 32'hFFFF_FFFF);
        check_rd(12'h320, 32'h7D, "inhibit_mask");
        wr(12'h320, 32'h0);
        check_rd(12'hB00, 32'hABCD_0003, "mcycle_still_frozen");
        step(1);
        check_rd(12'hB00, 32'hABCD_0004, "mcycle_unfrozen");

        // HPM_WIDTH wrap from all-ones.
        wr(12'h323, 32'd1);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        check_rd(12'hB83, 32'h0000_00FF, "hpm3h_width");
        event_vec = 8'h01;
        step(1);
        event_vec = 8'h00;
        check_rd(12'hB03, 32'hFFFF_FFFF, "hpm3_prewrap");
        step(1);
        check_rd(12'hB03, 32'h0, "hpm3_wrap_lo");
        check_rd(12'hB83, 32'h0, "hpm3_wrap_hi");
`ifdef MHPM_OVF_IRQ_EN
        check_rd(12'h323, 32'h8000_0001, "of_set");
        check1("ovf_irq_lag", ovf_irq, 1'b0);
        step(1);
        check1("ovf_irq_set", ovf_irq, 1'b1);
        wr(12'h323, 32'd1);
        check_rd(12'h323, 32'd1, "of_clear");
        step(1);
        check1("ovf_irq_clear", ovf_irq, 1'b0);
        wr(12'h323, 32'h4000_0001);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'h0000_00FF);
        event_vec = 8'h01;
        step(1);
        event_vec = 8'h00;
        step(3);
        check_rd(12'hB03, 32'h0, "oinh_wrap");
        check_rd(12'h323, 32'h4000_0001, "oinh_no_of");
        check1("oinh_irq", ovf_irq, 1'b0);
`else
        step(2);
        check1("ovf_irq_tied", ovf_irq, 1'b0);
        wr(12'h323, 32'hC000_0001);
        check_rd(12'h323, 32'h1, "of_bits_absent");
`endif

        // Reset mid-operation drops the pending retire pulse.
        inst_retired = 1'b1;
        step(1);
        inst_retired = 1'b0;
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        step(2);
        check_rd(12'hB02, 32'd0, "minstret_rst_drop");
        check_rd(12'hB00, 32'd2, "mcycle_after_rst");
        check1("ovf_irq_rst", ovf_irq, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
